// File: rtl/wb_pc_pkg.sv
// Shared types for the writeback / program-counter stage: PC source select,
// stage FSM states and the writeback source priority.
package wb_pc_pkg;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    JREG   = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_UART = 2'd1,
    HALTED    = 2'd2
  } state_e;

  // Writeback sources, listed from lowest to highest priority.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LINK = 2'd1,
    WB_MEM  = 2'd2,
    WB_UART = 2'd3
  } wb_src_e;

  function automatic wb_src_e wb_src_pick(input logic uart, input logic mem, input logic link);
    if (uart)      return WB_UART;
    else if (mem)  return WB_MEM;
    else if (link) return WB_LINK;
    else           return WB_ALU;
  endfunction

endpackage

// File: rtl/wb_pc_unit_next_pc_sel.sv
// Combinational next-PC selection. Flags a redirect whenever the chosen PC
// differs from the sequential successor.
module next_pc_sel
  import wb_pc_pkg::*;
#(
  parameter int IMW        = 2,
  parameter int DATA_WIDTH = 32
) (
  input  pc_src_e               pc_src_i,
  input  logic                  branch_taken_i,
  input  logic [IMW-1:0]        branch_target_i,
  input  logic [25:0]           inst_index_i,
  input  logic [DATA_WIDTH-1:0] register_data_i,
  input  logic [IMW-1:0]        pc_plus1_i,
  output logic [IMW-1:0]        next_pc_o,
  output logic                  redirect_o
);

  // Targets wider than the PC are truncated; the upper bits carry no meaning here.
  logic unused_hi;
  assign unused_hi = ^{inst_index_i[25:IMW], register_data_i[DATA_WIDTH-1:IMW]};

  always_comb begin
    next_pc_o = pc_plus1_i;
    case (pc_src_i)
      SEQ:    next_pc_o = pc_plus1_i;
      BRANCH: next_pc_o = branch_taken_i ? branch_target_i : pc_plus1_i;
      JUMP:   next_pc_o = inst_index_i[IMW-1:0];
      JREG:   next_pc_o = register_data_i[IMW-1:0];
      default: next_pc_o = pc_plus1_i;
    endcase
  end

  assign redirect_o = (next_pc_o != pc_plus1_i);

endmodule

// File: rtl/wb_pc_unit.sv
// Writeback + PC stage: selects and registers writeback data, owns the PC,
// blocks on UART reads and holds a halt state until reset.
module wb_pc_unit
  import wb_pc_pkg::*;
#(
  parameter int INST_MEM_WIDTH = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int RESET_PC       = 0,
  parameter int RETIRE_CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic                      reg_write_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  input  logic                      mem_to_reg,
  input  logic                      uart_to_reg,
  input  logic                      link_in,
  input  logic                      halt_in,
  input  pc_src_e                   pc_src,
  input  logic                      branch_taken,
  input  logic [DATA_WIDTH-1:0]     read_data,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [DATA_WIDTH-1:0]     register_data,
  input  logic [25:0]               inst_index,
  input  logic [INST_MEM_WIDTH-1:0] branch_target,
  input  logic [INST_MEM_WIDTH-1:0] pc_plus1,
  input  logic                      uart_valid,
  input  logic [DATA_WIDTH-1:0]     uart_data,
  output logic                      uart_ready,
  output logic                      stall,
  output logic                      reg_write_out,
  output logic [REG_ADDR_WIDTH-1:0] rd_out,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [INST_MEM_WIDTH-1:0] pc,
  output logic                      flush,
  output logic                      halted,
  output logic [RETIRE_CNT_W-1:0]   retired,
  output state_e                    dbg_state
);

  localparam logic [INST_MEM_WIDTH-1:0] RESET_PC_V = INST_MEM_WIDTH'(RESET_PC);

  // UART handshake: data transfers in a cycle where uart_valid && uart_ready.
  // uart_ready is only raised by a retiring UART read; upstream holds all
  // WB inputs stable for as long as stall is high.

  state_e                    state_q, state_d;
  logic [INST_MEM_WIDTH-1:0] pc_q, pc_d;
  logic                      reg_write_q, reg_write_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic                      flush_q, flush_d;
  logic [RETIRE_CNT_W-1:0]   retired_q, retired_d;

  logic                      retire;
  logic [INST_MEM_WIDTH-1:0] next_pc;
  logic                      redirect;
  logic [DATA_WIDTH-1:0]     wb_sel;

  next_pc_sel #(
    .IMW       (INST_MEM_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_next_pc_sel (
    .pc_src_i       (pc_src),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .inst_index_i   (inst_index),
    .register_data_i(register_data),
    .pc_plus1_i     (pc_plus1),
    .next_pc_o      (next_pc),
    .redirect_o     (redirect)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (valid_in) begin
          if (uart_to_reg && !uart_valid) begin
            stall   = 1'b1;
            state_d = WAIT_UART;
          end else begin
            retire  = 1'b1;
            state_d = halt_in ? HALTED : RUN;
          end
        end
      end
      WAIT_UART: begin
        if (uart_valid) begin
          retire  = 1'b1;
          state_d = halt_in ? HALTED : RUN;
        end else begin
          stall = 1'b1;
        end
      end
      HALTED: stall = 1'b1;
      default: state_d = RUN;
    endcase
  end

  // Gated by reset so an abandoned read never consumes UART data.
  assign uart_ready = retire && uart_to_reg && !reset;

  always_comb begin
    wb_sel = alu_result;
    case (wb_src_pick(uart_to_reg, mem_to_reg, link_in))
      WB_UART: wb_sel = uart_data;
      WB_MEM:  wb_sel = read_data;
      WB_LINK: wb_sel = DATA_WIDTH'(pc_plus1);
      WB_ALU:  wb_sel = alu_result;
      default: wb_sel = alu_result;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    wb_data_d   = wb_data_q;
    flush_d     = 1'b0;
    retired_d   = retired_q;
    if (retire) begin
      reg_write_d = reg_write_in && (rd_in != '0);
      rd_d        = rd_in;
      wb_data_d   = wb_sel;
      retired_d   = retired_q + RETIRE_CNT_W'(1);
      // A halting instruction freezes the PC, so nothing younger is redirected.
      if (!halt_in) begin
        pc_d    = next_pc;
        flush_d = redirect;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC_V;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wb_data_q   <= '0;
      flush_q     <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wb_data_q   <= wb_data_d;
      flush_q     <= flush_d;
      retired_q   <= retired_d;
    end
  end

  assign reg_write_out = reg_write_q;
  assign rd_out        = rd_q;
  assign wb_data       = wb_data_q;
  assign pc            = pc_q;
  assign flush         = flush_q;
  assign halted        = (state_q == HALTED);
  assign retired       = retired_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_wb_pc_unit.sv
// Bench for wb_pc_unit: directed cases plus randomized instructions, with a
// retire scoreboard fed by a spec-level model and drained by a monitor.
module tb_wb_pc_unit;
  import wb_pc_pkg::*;

  localparam int IMW = 4;
  localparam int DW  = 32;
  localparam int RAW = 5;
  localparam int CW  = 32;
  localparam int RST_PC = 3;
  localparam int EW  = 1 + RAW + DW + IMW + 1 + 1 + CW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           valid_in, reg_write_in, mem_to_reg, uart_to_reg, link_in, halt_in;
  logic [RAW-1:0] rd_in;
  pc_src_e        pc_src;
  logic           branch_taken;
  logic [DW-1:0]  read_data, alu_result, register_data, uart_data;
  logic [25:0]    inst_index;
  logic [IMW-1:0] branch_target, pc_plus1;
  logic           uart_valid;
  logic           uart_ready, stall, reg_write_out, flush, halted;
  logic [RAW-1:0] rd_out;
  logic [DW-1:0]  wb_data;
  logic [IMW-1:0] pc;
  logic [CW-1:0]  retired;
  state_e         dbg_state;

  wb_pc_unit #(
    .INST_MEM_WIDTH(IMW), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW),
    .RESET_PC(RST_PC), .RETIRE_CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .reg_write_in(reg_write_in),
    .rd_in(rd_in), .mem_to_reg(mem_to_reg), .uart_to_reg(uart_to_reg),
    .link_in(link_in), .halt_in(halt_in), .pc_src(pc_src),
    .branch_taken(branch_taken), .read_data(read_data), .alu_result(alu_result),
    .register_data(register_data), .inst_index(inst_index),
    .branch_target(branch_target), .pc_plus1(pc_plus1), .uart_valid(uart_valid),
    .uart_data(uart_data), .uart_ready(uart_ready), .stall(stall),
    .reg_write_out(reg_write_out), .rd_out(rd_out), .wb_data(wb_data), .pc(pc),
    .flush(flush), .halted(halted), .retired(retired), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [EW-1:0]  exp_q[$];
  logic [IMW-1:0] m_pc;
  logic [CW-1:0]  m_retired;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_expected();
    logic [DW-1:0]  wb;
    logic [IMW-1:0] nxt;
    logic           rw, fl;
    if (uart_to_reg)     wb = uart_data;
    else if (mem_to_reg) wb = read_data;
    else if (link_in)    wb = DW'(pc_plus1);
    else                 wb = alu_result;
    case (pc_src)
      BRANCH:  nxt = branch_taken ? branch_target : pc_plus1;
      JUMP:    nxt = IMW'(inst_index % (1 << IMW));
      JREG:    nxt = IMW'(register_data % (1 << IMW));
      default: nxt = pc_plus1;
    endcase
    rw = reg_write_in && (rd_in != 0);
    fl = !halt_in && (nxt != pc_plus1);
    m_retired = m_retired + 1;
    if (!halt_in) m_pc = nxt;
    exp_q.push_back({rw, rd_in, wb, m_pc, fl, halt_in, m_retired});
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_fields();
    valid_in = 0; reg_write_in = 0; rd_in = '0; mem_to_reg = 0; uart_to_reg = 0;
    link_in = 0; halt_in = 0; pc_src = SEQ; branch_taken = 0; read_data = '0;
    alu_result = '0; register_data = '0; inst_index = '0; branch_target = '0;
    pc_plus1 = '0; uart_valid = 0; uart_data = '0;
  endtask

  task automatic rand_fields();
    reg_write_in  = 1'($urandom_range(0, 1));
    rd_in         = ($urandom_range(0, 3) == 0) ? '0 : RAW'($urandom_range(1, 31));
    mem_to_reg    = 1'($urandom_range(0, 1));
    link_in       = 1'($urandom_range(0, 1));
    uart_to_reg   = ($urandom_range(0, 3) == 0);
    halt_in       = 0;
    pc_src        = pc_src_e'($urandom_range(0, 3));
    branch_taken  = 1'($urandom_range(0, 1));
    read_data     = $urandom();
    alu_result    = $urandom();
    register_data = $urandom();
    uart_data     = $urandom();
    inst_index    = 26'($urandom());
    branch_target = IMW'($urandom_range(0, 15));
    pc_plus1      = m_pc + 1'b1;
    uart_valid    = 1'($urandom_range(0, 1));
  endtask

  // Entered and left at posedge+1; uart_valid stays low for 'delay' cycles.
  task automatic issue(input int delay);
    logic [IMW-1:0] pc_before;
    pc_before = m_pc;
    valid_in = 1;
    if (uart_to_reg) uart_valid = (delay == 0);
    push_expected();
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("wait_stall", stall, 1);
      check("wait_uart_ready", uart_ready, 0);
      check("wait_pc_hold", pc, pc_before);
      @(posedge clk); #1;
      if (i == delay - 1) uart_valid = 1;
    end
    @(negedge clk);
    check("retire_stall", stall, 0);
    check("retire_uart_ready", uart_ready, uart_to_reg);
    @(posedge clk); #1;
    valid_in = 0;
    uart_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 0;
      uart_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_stall", stall, 0);
      check("idle_uart_ready", uart_ready, 0);
      check("idle_pc_hold", pc, m_pc);
      @(posedge clk); #1;
    end
    uart_valid = 0;
  endtask

  task automatic apply_reset();
    reset = 1;
    clear_fields();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pc", pc, RST_PC);
    check("rst_reg_write", reg_write_out, 0);
    check("rst_rd", rd_out, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_flush", flush, 0);
    check("rst_halted", halted, 0);
    check("rst_retired", retired, 0);
    check("rst_state", dbg_state, RUN);
    check("rst_stall", stall, 0);
    check("rst_uart_ready", uart_ready, 0);
    check("rst_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    reset = 0;
    m_pc = RST_PC;
    m_retired = '0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [CW-1:0] prev;
    logic [EW-1:0] e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = '0;
      end else if (retired !== prev) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_retire: got retired=%0d expected no retire", retired);
        end else begin
          e = exp_q.pop_front();
          check("reg_write_out", reg_write_out, e[EW-1]);
          check("rd_out", rd_out, e[EW-2 -: RAW]);
          check("wb_data", wb_data, e[EW-2-RAW -: DW]);
          check("pc", pc, e[EW-2-RAW-DW -: IMW]);
          check("flush", flush, e[CW+1]);
          check("halted", halted, e[CW]);
          check("retired", retired, e[CW-1:0]);
        end
        prev = retired;
      end else begin
        check("noretire_reg_write", reg_write_out, 0);
        check("noretire_flush", flush, 0);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: got timeout expected $finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_fields();
    m_pc = RST_PC;
    m_retired = '0;
    apply_reset();

    // ALU write, sequential PC
    clear_fields(); reg_write_in = 1; rd_in = 7; alu_result = 32'h1234; pc_plus1 = 1;
    issue(0);
    // write to r0 is suppressed, PC still advances
    clear_fields(); reg_write_in = 1; rd_in = 0; alu_result = 32'hDEAD; pc_plus1 = 2;
    issue(0);
    // blocking UART read, data late by 3 cycles
    clear_fields(); uart_to_reg = 1; mem_to_reg = 1; reg_write_in = 1; rd_in = 5;
    uart_data = 32'h41; pc_plus1 = 3;
    issue(3);
    idle(1);
    // jump with wide index truncated to the PC width
    clear_fields(); pc_src = JUMP; inst_index = 26'h3FFFFF5; pc_plus1 = 4;
    issue(0);
    // branch not taken
    clear_fields(); pc_src = BRANCH; branch_taken = 0; branch_target = 9; pc_plus1 = 15;
    issue(0);
    // link write with register jump, PC+1 wrapping to 0
    clear_fields(); link_in = 1; reg_write_in = 1; rd_in = 31; pc_plus1 = 0;
    pc_src = JREG; register_data = 32'hABCD_0127;
    issue(0);
    idle(2);

    for (int n = 0; n < 80; n++) begin
      rand_fields();
      issue(uart_to_reg ? $urandom_range(0, 3) : 0);
      idle($urandom_range(0, 2));
    end

    // HALT with a register write, then held for 10 cycles
    clear_fields(); halt_in = 1; reg_write_in = 1; rd_in = 9; alu_result = 32'hBEEF;
    pc_plus1 = m_pc + 1'b1;
    issue(0);
    for (int i = 0; i < 10; i++) begin
      rand_fields();
      valid_in = 1;
      @(negedge clk);
      check("halt_stall", stall, 1);
      check("halt_uart_ready", uart_ready, 0);
      check("halt_flag", halted, 1);
      check("halt_pc", pc, m_pc);
      check("halt_state", dbg_state, HALTED);
      @(posedge clk); #1;
    end
    apply_reset();

    // reset while waiting on UART abandons the read
    clear_fields(); uart_to_reg = 1; reg_write_in = 1; rd_in = 3; uart_data = 32'h99;
    valid_in = 1;
    @(negedge clk);
    check("abort_stall", stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_state_wait", dbg_state, WAIT_UART);
    @(posedge clk); #1;
    reset = 1;
    uart_valid = 1;
    @(negedge clk);
    check("abort_uart_ready", uart_ready, 0);
    @(posedge clk); #1;
    valid_in = 0;
    uart_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_state_run", dbg_state, RUN);
    check("abort_pc", pc, RST_PC);
    check("abort_retired", retired, 0);
    @(posedge clk); #1;
    reset = 0;
    m_pc = RST_PC;
    m_retired = '0;

    clear_fields(); reg_write_in = 1; rd_in = 2; alu_result = 32'h5A5A; pc_plus1 = 4;
    issue(0);
    idle(2);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
